// File: rtl/mux4_rr_arbiter.sv
// rtl/mux4_rr_arbiter.sv - round-robin arbiter driving a shared 4:1 data mux with bounded bursts
// Optional per-requester grant statistics enabled by MUX4_ARB_STATS_EN.
module mux4_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] din,
    input  logic               dout_ready,
    output logic [3:0]         gnt,
    output logic [1:0]         sel,
    output logic [WIDTH-1:0]   dout,
    output logic               dout_valid
`ifdef MUX4_ARB_STATS_EN
    ,
    output logic [31:0]        grant_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] gnt_q, gnt_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       win_found;
    logic [1:0] win_idx;
    logic       beat;

    // Search starts just after the last owner so the last owner is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            if (!win_found && req[2'(ptr_q + 2'(i))]) begin
                win_found = 1'b1;
                win_idx   = 2'(ptr_q + 2'(i));
            end
        end
    end

    assign dout       = din[32'(sel_q) * WIDTH +: WIDTH];
    assign dout_valid = (state_q == BUSY) && req[sel_q];
    assign beat       = dout_valid && dout_ready;
    assign gnt        = gnt_q;
    assign sel        = sel_q;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = BUSY;
                    sel_d      = win_idx;
                    gnt_d      = 4'b0001 << win_idx;
                    beat_cnt_d = 8'd0;
                end
            end
            BUSY: begin
                // A dropped request never carries a beat, so a drop on the last beat is one release.
                if (!req[sel_q] || (beat && beat_cnt_q == LAST_BEAT)) begin
                    state_d = IDLE;
                    ptr_d   = sel_q;
                    gnt_d   = 4'b0000;
                end else if (beat) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ptr_q      <= 2'd3;
            sel_q      <= 2'd0;
            gnt_q      <= 4'b0000;
            beat_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

`ifdef MUX4_ARB_STATS_EN
    logic [7:0] stat_q [4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) stat_q[k] <= 8'd0;
        end else if (state_q == IDLE && win_found && stat_q[win_idx] != 8'hFF) begin
            stat_q[win_idx] <= stat_q[win_idx] + 8'd1;
        end
    end

    assign grant_cnt = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb/tb_mux4_rr_arbiter.sv - directed bench for mux4_rr_arbiter with a behavioural reference model
module tb_mux4_rr_arbiter;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic               clk;
    logic               rst_n;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] din;
    logic               dout_ready;
    logic [3:0]         gnt;
    logic [1:0]         sel;
    logic [WIDTH-1:0]   dout;
    logic               dout_valid;
`ifdef MUX4_ARB_STATS_EN
    logic [31:0]        grant_cnt;
`endif

    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .din        (din),
        .dout_ready (dout_ready),
        .gnt        (gnt),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid)
`ifdef MUX4_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the mux, how many beats it has moved, who went last.
    bit  m_busy;
    int  m_owner;
    int  m_ptr;
    int  m_beats;
    int  m_cnt [4];
    int  m_win;
    int  cyc = 0;
    int  grant_q [$];
    int  gcyc_q  [$];
    int  beats_q [$];

    function automatic int pick(input int p, input logic [3:0] r);
        for (int i = 1; i <= 4; i++) begin
            if (r[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    always_comb m_win = pick(m_ptr, req);

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_owner <= 0;
            m_ptr   <= 3;
            m_beats <= 0;
            for (int k = 0; k < 4; k++) m_cnt[k] <= 0;
        end else if (!m_busy) begin
            if (m_win >= 0) begin
                m_busy  <= 1'b1;
                m_owner <= m_win;
                m_beats <= 0;
                grant_q.push_back(m_win);
                gcyc_q.push_back(cyc);
                if (m_cnt[m_win] < 255) m_cnt[m_win] <= m_cnt[m_win] + 1;
            end
        end else if (!req[m_owner]) begin
            m_busy <= 1'b0;
            m_ptr  <= m_owner;
            beats_q.push_back(m_beats);
        end else if (dout_ready) begin
            if (m_beats + 1 == MAX_HOLD) begin
                m_busy <= 1'b0;
                m_ptr  <= m_owner;
                beats_q.push_back(m_beats + 1);
            end else begin
                m_beats <= m_beats + 1;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_gnt",   {28'd0, gnt},   m_busy ? (32'd1 << m_owner) : 32'd0);
        check("cyc_sel",   {30'd0, sel},   32'(m_owner));
        check("cyc_valid", {31'd0, dout_valid}, {31'd0, m_busy && req[m_owner]});
        check("cyc_dout",  {24'd0, dout},  {24'd0, din[m_owner*WIDTH +: WIDTH]});
`ifdef MUX4_ARB_STATS_EN
        check("cyc_stats", grant_cnt, {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]});
`endif
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        grant_q.delete();
        gcyc_q.delete();
        beats_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req        = 4'b0000;
        dout_ready = 1'b1;
        din        = {8'h44, 8'h33, 8'h22, 8'hA5};

        apply_reset();
        check("reset_gnt",   {28'd0, gnt}, 32'h0);
        check("reset_sel",   {30'd0, sel}, 32'h0);
        check("reset_valid", {31'd0, dout_valid}, 32'h0);

        // single requester: 4 beats, one bubble, re-grant
        req = 4'b0001;
        step();
        check("t1_gnt",  {28'd0, gnt}, 32'b0001);
        check("t1_sel",  {30'd0, sel}, 32'd0);
        check("t1_dout", {24'd0, dout}, 32'hA5);
        repeat (4) step();
        check("t1_release", {28'd0, gnt}, 32'h0);
        step();
        check("t1_regrant", {28'd0, gnt}, 32'b0001);
        req = 4'b0000;
        repeat (4) step();
        check("t1_ngrants", grant_q.size(), 32'd2);
        check("t1_beats",   beats_q[0], 32'd4);
        check("t1_gap",     gcyc_q[1] - gcyc_q[0], 32'd5);

        // round-robin fairness from reset
        apply_reset();
        din = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        req = 4'b1111;
        repeat (25) step();
        req = 4'b0000;
        repeat (6) step();
        check("t2_ngrants", (grant_q.size() >= 5) ? 32'd1 : 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) check("t2_order", grant_q[i], 32'(i % 4));
        for (int i = 0; i < 4; i++) begin
            check("t2_beats", beats_q[i], 32'd4);
            check("t2_gap",   gcyc_q[i+1] - gcyc_q[i], 32'd5);
        end

        // early release after 2 beats, requester 3 next
        apply_reset();
        din = {8'h5C, 8'h3B, 8'h7E, 8'h01};
        req = 4'b0100;
        step();
        check("t3_gnt", {28'd0, gnt}, 32'b0100);
        repeat (2) step();
        req = 4'b1001;
        step();
        check("t3_release", {28'd0, gnt}, 32'h0);
        check("t3_ptr",     m_ptr, 32'd2);
        check("t3_beats",   beats_q[0], 32'd2);
        step();
        check("t3_next", {28'd0, gnt}, 32'b1000);
        check("t3_sel",  {30'd0, sel}, 32'd3);
        req = 4'b0000;
        repeat (4) step();

        // backpressure holds the grant without consuming beats
        apply_reset();
        din = {8'h99, 8'h88, 8'h6D, 8'h10};
        req = 4'b0010;
        dout_ready = 1'b0;
        step();
        check("t4_gnt", {28'd0, gnt}, 32'b0010);
        repeat (10) begin
            step();
            check("t4_hold_valid", {31'd0, dout_valid}, 32'd1);
            check("t4_hold_gnt",   {28'd0, gnt}, 32'b0010);
        end
        dout_ready = 1'b1;
        repeat (3) step();
        check("t4_still", {28'd0, gnt}, 32'b0010);
        step();
        check("t4_release", {28'd0, gnt}, 32'h0);
        check("t4_beats",   beats_q[0], 32'd4);
        req = 4'b0000;
        repeat (4) step();

        // owner drops on its final beat: single release, one bubble
        apply_reset();
        req = 4'b0011;
        step();
        check("t5_gnt", {28'd0, gnt}, 32'b0001);
        repeat (3) step();
        req = 4'b0010;
        step();
        check("t5_release", {28'd0, gnt}, 32'h0);
        step();
        check("t5_next",    {28'd0, gnt}, 32'b0010);
        check("t5_ngrants", grant_q.size(), 32'd2);
        req = 4'b0000;
        repeat (6) step();

        // asynchronous reset in the middle of a burst
        apply_reset();
        din = {8'hF0, 8'hE1, 8'hD2, 8'hC3};
        req = 4'b0100;
        step();
        check("t6_gnt", {28'd0, gnt}, 32'b0100);
`ifdef MUX4_ARB_STATS_EN
        check("t6_stats_pre", grant_cnt, 32'h0001_0000);
`endif
        step();
        #1;
        rst_n = 1'b0;
        req   = 4'b1111;
        #1;
        check("t6_rst_gnt",   {28'd0, gnt}, 32'h0);
        check("t6_rst_sel",   {30'd0, sel}, 32'h0);
        check("t6_rst_valid", {31'd0, dout_valid}, 32'h0);
`ifdef MUX4_ARB_STATS_EN
        check("t6_rst_stats", grant_cnt, 32'h0);
`endif
        step();
        rst_n = 1'b1;
        step();
        check("t6_first", {28'd0, gnt}, 32'b0001);
        check("t6_sel",   {30'd0, sel}, 32'd0);
        req = 4'b0000;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
